// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared types and lane helpers for the memory-stage unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mau_state_t;

    function automatic logic [3:0] lane_mask(input mem_size_t size, input logic [1:0] a);
        logic [3:0] mask;
        case (size)
            MEM_BYTE: mask = 4'b0001 << a;
            MEM_HALF: mask = 4'b0011 << a;
            default:  mask = 4'b1111;
        endcase
        return mask;
    endfunction

    function automatic logic [31:0] lane_data(input mem_size_t size, input logic [31:0] d);
        logic [31:0] data;
        case (size)
            MEM_BYTE: data = {4{d[7:0]}};
            MEM_HALF: data = {2{d[15:0]}};
            default:  data = d;
        endcase
        return data;
    endfunction

    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] a);
        logic mis;
        case (size)
            MEM_HALF: mis = a[0];
            MEM_WORD: mis = (a != 2'b00);
            default:  mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_fb_write_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fb_write_fifo
// Description : Synchronous posting FIFO for framebuffer pixel writes.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_write_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] c_full_count = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full     = (r_count == c_full_count);
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];
    assign w_push   = push & ~full;
    assign w_pop    = pop & ~empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Memory-stage load/store engine with req/ack data bus and
//               posted framebuffer writes.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int RESOLUTION_X   = 400,
    parameter int RESOLUTION_Y   = 300,
    parameter int PALETTE_LENGTH = 256,
    parameter int FB_FIFO_DEPTH  = 4,
    localparam int XW = $clog2(RESOLUTION_X),
    localparam int YW = $clog2(RESOLUTION_Y),
    localparam int PW = $clog2(PALETTE_LENGTH),
    localparam int CW = $clog2(FB_FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m_valid,
    input  logic          m_mem_read,
    input  logic          m_mem_write,
    input  logic          m_fb_write,
    input  logic [1:0]    m_mem_size,
    input  logic [31:0]   m_addr,
    input  logic [31:0]   m_wr_data,
    output logic          m_stall,
    output logic          m_misaligned,
    output logic [31:0]   m_rd_data,
    output logic          dbus_req,
    input  logic          dbus_ack,
    output logic [31:0]   dbus_addr,
    output logic [31:0]   dbus_wr_data,
    output logic [3:0]    dbus_wr_en,
    input  logic [31:0]   dbus_rd_data,
    output logic          fb_wr_en,
    input  logic          fb_wr_ready,
    output logic [XW-1:0] fb_wr_pxl_x,
    output logic [YW-1:0] fb_wr_pxl_y,
    output logic [PW-1:0] fb_wr_pxl_value,
    output logic [CW-1:0] fb_fifo_count
);

    localparam int FW = XW + YW + PW;

    mau_state_t  r_state;
    mau_state_t  w_next_state;
    mem_size_t   w_size;
    logic [31:0] r_addr;
    logic [31:0] r_wr_data;
    logic [3:0]  r_wr_en;
    logic        r_is_read;
    logic [31:0] r_rd_data;
    logic        w_access;
    logic        w_misal;
    logic        w_start;
    logic        w_fb_req;
    logic        w_fb_push;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [FW-1:0] w_head;

    assign w_size   = mem_size_t'(m_mem_size);
    assign w_access = m_valid & (m_mem_read | m_mem_write) & ~m_fb_write;
    assign w_misal  = is_misaligned(w_size, m_addr[1:0]);
    assign w_start  = w_access & ~w_misal;
    assign w_fb_req = m_valid & m_fb_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start)  w_next_state = BUSY;
            BUSY:    if (dbus_ack) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // A full FIFO holds the pixel store; it pushes once a slot has actually freed.
    always_comb begin
        m_stall      = 1'b0;
        m_misaligned = 1'b0;
        w_fb_push    = 1'b0;
        case (r_state)
            IDLE: begin
                m_misaligned = w_access & w_misal;
                m_stall      = w_start | (w_fb_req & w_fifo_full);
                w_fb_push    = w_fb_req & ~w_fifo_full;
            end
            BUSY:    m_stall = 1'b1;
            default: m_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr    <= '0;
            r_wr_data <= '0;
            r_wr_en   <= '0;
            r_is_read <= 1'b0;
            r_rd_data <= '0;
        end else begin
            if (r_state == IDLE && w_start) begin
                r_addr    <= {m_addr[31:2], 2'b00};
                r_wr_data <= lane_data(w_size, m_wr_data);
                r_wr_en   <= m_mem_write ? lane_mask(w_size, m_addr[1:0]) : 4'b0000;
                r_is_read <= ~m_mem_write;
            end
            if (r_state == BUSY && dbus_ack && r_is_read) begin
                r_rd_data <= dbus_rd_data;
            end
        end
    end

    assign dbus_req     = (r_state == BUSY);
    assign dbus_addr    = r_addr;
    assign dbus_wr_data = r_wr_data;
    assign dbus_wr_en   = r_wr_en;
    assign m_rd_data    = r_rd_data;

    fb_write_fifo #(
        .WIDTH (FW),
        .DEPTH (FB_FIFO_DEPTH)
    ) u_fb_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_fb_push),
        .push_data ({m_addr[XW-1:0], m_addr[16 +: YW], m_wr_data[PW-1:0]}),
        .pop       (fb_wr_ready),
        .pop_data  (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (fb_fifo_count)
    );

    assign fb_wr_en        = ~w_fifo_empty;
    assign fb_wr_pxl_x     = w_head[FW-1 -: XW];
    assign fb_wr_pxl_y     = w_head[PW +: YW];
    assign fb_wr_pxl_value = w_head[PW-1:0];

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed scoreboard bench for mem_access_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid, m_mem_read, m_mem_write, m_fb_write;
    logic [1:0]  m_mem_size;
    logic [31:0] m_addr, m_wr_data;
    logic        m_stall, m_misaligned;
    logic [31:0] m_rd_data;
    logic        dbus_req, dbus_ack;
    logic [31:0] dbus_addr, dbus_wr_data, dbus_rd_data;
    logic [3:0]  dbus_wr_en;
    logic        fb_wr_en, fb_wr_ready;
    logic [8:0]  fb_wr_pxl_x, fb_wr_pxl_y;
    logic [7:0]  fb_wr_pxl_value;
    logic [2:0]  fb_fifo_count;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  wr_en;
        logic        chk_data;
    } bus_exp_t;

    bus_exp_t    bus_q[$];
    logic [25:0] pix_q[$];
    int checks   = 0;
    int failures = 0;

    mem_access_unit dut (
        .clk             (clk),
        .reset           (reset),
        .m_valid         (m_valid),
        .m_mem_read      (m_mem_read),
        .m_mem_write     (m_mem_write),
        .m_fb_write      (m_fb_write),
        .m_mem_size      (m_mem_size),
        .m_addr          (m_addr),
        .m_wr_data       (m_wr_data),
        .m_stall         (m_stall),
        .m_misaligned    (m_misaligned),
        .m_rd_data       (m_rd_data),
        .dbus_req        (dbus_req),
        .dbus_ack        (dbus_ack),
        .dbus_addr       (dbus_addr),
        .dbus_wr_data    (dbus_wr_data),
        .dbus_wr_en      (dbus_wr_en),
        .dbus_rd_data    (dbus_rd_data),
        .fb_wr_en        (fb_wr_en),
        .fb_wr_ready     (fb_wr_ready),
        .fb_wr_pxl_x     (fb_wr_pxl_x),
        .fb_wr_pxl_y     (fb_wr_pxl_y),
        .fb_wr_pxl_value (fb_wr_pxl_value),
        .fb_fifo_count   (fb_fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_valid     = 1'b0;
        m_mem_read  = 1'b0;
        m_mem_write = 1'b0;
        m_fb_write  = 1'b0;
        m_mem_size  = 2'd0;
        m_addr      = '0;
        m_wr_data   = '0;
    endtask

    task automatic check_head(input string tag);
        logic [25:0] e;
        if (pix_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = pix_q[0];
            check(tag, {6'd0, fb_wr_pxl_x, fb_wr_pxl_y, fb_wr_pxl_value}, {6'd0, e});
        end
    endtask

    // Drives one aligned load/store; the responder acks after ack_delay request cycles.
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int ack_delay, input logic [31:0] exp_addr,
                             input logic [3:0] exp_en, input logic [31:0] exp_data,
                             input int exp_stall, input int exp_req);
        int stalls = 0;
        int reqs   = 0;
        int seen   = 0;
        bit done   = 0;
        bit popped = 0;
        bus_exp_t e;
        bus_q.push_back('{addr: exp_addr, data: exp_data, wr_en: exp_en, chk_data: wr});
        m_valid = 1'b1; m_mem_read = rd; m_mem_write = wr; m_fb_write = 1'b0;
        m_mem_size = size; m_addr = addr; m_wr_data = wdata; dbus_rd_data = rdata;
        for (int c = 0; c < 40 && !done; c++) begin
            if (dbus_req) begin
                dbus_ack = (seen == ack_delay);
                seen++;
            end else begin
                dbus_ack = 1'b0;
            end
            @(negedge clk);
            stalls += int'(m_stall);
            reqs   += int'(dbus_req);
            if (dbus_req && !popped) begin
                popped = 1;
                if (bus_q.size() == 0) begin
                    check({tag, "_sb_empty"}, 32'd1, 32'd0);
                end else begin
                    e = bus_q.pop_front();
                    check({tag, "_addr"}, dbus_addr, e.addr);
                    check({tag, "_wr_en"}, {28'd0, dbus_wr_en}, {28'd0, e.wr_en});
                    if (e.chk_data) check({tag, "_wr_data"}, dbus_wr_data, e.data);
                end
            end
            if (!m_stall) begin
                done = 1;
                if (rd) check({tag, "_rd_data"}, m_rd_data, rdata);
            end
            next_cycle();
        end
        if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
        idle_inputs();
        dbus_ack = 1'b0;
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
        check({tag, "_req_cycles"}, 32'(reqs), 32'(exp_req));
    endtask

    initial begin
        idle_inputs();
        reset        = 1'b1;
        dbus_ack     = 1'b1;
        dbus_rd_data = 32'hDEAD_BEEF;
        fb_wr_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_req", {31'd0, dbus_req}, 32'd0);
        check("rst_stall", {31'd0, m_stall}, 32'd0);
        check("rst_count", {29'd0, fb_fifo_count}, 32'd0);
        check("rst_fb_en", {31'd0, fb_wr_en}, 32'd0);
        check("rst_rd_data", m_rd_data, 32'd0);
        check("rst_wr_en", {28'd0, dbus_wr_en}, 32'd0);
        check("rst_addr", dbus_addr, 32'd0);
        next_cycle();
        dbus_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_req", {31'd0, dbus_req}, 32'd0);
        next_cycle();

        do_access("sw", 1'b0, 1'b1, 2'd2, 32'h104, 32'hAABB_CCDD, 32'h0, 1,
                  32'h104, 4'b1111, 32'hAABB_CCDD, 3, 2);
        do_access("sb", 1'b0, 1'b1, 2'd0, 32'h203, 32'h0000_005A, 32'h0, 0,
                  32'h200, 4'b1000, 32'h5A5A_5A5A, 2, 1);
        do_access("lw", 1'b1, 1'b0, 2'd2, 32'h8, 32'h0, 32'h1234_5678, 0,
                  32'h8, 4'b0000, 32'h0, 2, 1);
        do_access("sh", 1'b0, 1'b1, 2'd1, 32'h2, 32'h0000_1234, 32'h0, 2,
                  32'h0, 4'b1100, 32'h1234_1234, 4, 3);
        @(negedge clk);
        check("rd_data_held", m_rd_data, 32'h1234_5678);
        next_cycle();
        do_access("lb", 1'b1, 1'b0, 2'd0, 32'h1001, 32'h0, 32'hCAFE_F00D, 0,
                  32'h1000, 4'b0000, 32'h0, 2, 1);

        // Misaligned accesses are dropped without a bus request or stall.
        m_valid = 1'b1; m_mem_read = 1'b1; m_mem_size = 2'd1; m_addr = 32'h3;
        @(negedge clk);
        check("lh_mis", {31'd0, m_misaligned}, 32'd1);
        check("lh_mis_req", {31'd0, dbus_req}, 32'd0);
        check("lh_mis_stall", {31'd0, m_stall}, 32'd0);
        next_cycle();
        m_mem_read = 1'b0; m_mem_write = 1'b1; m_mem_size = 2'd2; m_addr = 32'h6;
        @(negedge clk);
        check("sw_mis", {31'd0, m_misaligned}, 32'd1);
        check("sw_mis_req", {31'd0, dbus_req}, 32'd0);
        next_cycle();
        m_valid = 1'b0; m_mem_write = 1'b0; m_mem_read = 1'b1; m_addr = 32'h10;
        @(negedge clk);
        check("invalid_stall", {31'd0, m_stall}, 32'd0);
        check("invalid_mis", {31'd0, m_misaligned}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("invalid_req", {31'd0, dbus_req}, 32'd0);
        next_cycle();
        idle_inputs();

        // Pixel posting: four fit, the fifth stalls until a slot frees.
        fb_wr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            m_valid = 1'b1; m_fb_write = 1'b1; m_mem_write = (i == 1);
            m_addr    = (32'(20 + i) << 16) | 32'(10 + i);
            m_wr_data = 32'h100 | 32'(8'h30 + i);
            @(negedge clk);
            check("fb_count", {29'd0, fb_fifo_count}, 32'(i));
            check("fb_req", {31'd0, dbus_req}, 32'd0);
            check("fb_stall", {31'd0, m_stall}, (i < 4) ? 32'd0 : 32'd1);
            if (i > 0) check_head("fb_head_stable");
            if (i < 4) begin
                pix_q.push_back({9'(10 + i), 9'(20 + i), 8'(8'h30 + i)});
                next_cycle();
            end
        end
        next_cycle();
        fb_wr_ready = 1'b1;
        @(negedge clk);
        check("fb_full_pop_stall", {31'd0, m_stall}, 32'd1);
        check("fb_full_count", {29'd0, fb_fifo_count}, 32'd4);
        check_head("fb_pop");
        void'(pix_q.pop_front());
        next_cycle();
        @(negedge clk);
        check("fb_stall_drop", {31'd0, m_stall}, 32'd0);
        check("fb_pushpop_count", {29'd0, fb_fifo_count}, 32'd3);
        pix_q.push_back({9'd14, 9'd24, 8'h34});
        check_head("fb_pop");
        void'(pix_q.pop_front());
        next_cycle();
        idle_inputs();
        for (int c = 0; c < 20 && pix_q.size() > 0; c++) begin
            @(negedge clk);
            if (fb_wr_en) begin
                check_head("fb_drain");
                void'(pix_q.pop_front());
            end
            next_cycle();
        end
        if (pix_q.size() != 0) check("fb_drain_timeout", 32'd0, 32'd1);
        @(negedge clk);
        check("fb_empty_count", {29'd0, fb_fifo_count}, 32'd0);
        check("fb_empty_en", {31'd0, fb_wr_en}, 32'd0);
        next_cycle();

        // Reset in the middle of a bus access.
        fb_wr_ready = 1'b0;
        m_valid = 1'b1; m_fb_write = 1'b1; m_addr = 32'h0005_0007; m_wr_data = 32'h9;
        next_cycle();
        idle_inputs();
        m_valid = 1'b1; m_mem_write = 1'b1; m_mem_size = 2'd2; m_addr = 32'h40;
        m_wr_data = 32'h1111_2222;
        @(negedge clk);
        check("rb_start_stall", {31'd0, m_stall}, 32'd1);
        check("rb_count", {29'd0, fb_fifo_count}, 32'd1);
        next_cycle();
        @(negedge clk);
        check("rb_busy_req", {31'd0, dbus_req}, 32'd1);
        check("rb_busy_addr", dbus_addr, 32'h40);
        next_cycle();
        reset = 1'b1;
        idle_inputs();
        next_cycle();
        reset    = 1'b0;
        dbus_ack = 1'b1;
        @(negedge clk);
        check("rb_req", {31'd0, dbus_req}, 32'd0);
        check("rb_count0", {29'd0, fb_fifo_count}, 32'd0);
        check("rb_fb_en", {31'd0, fb_wr_en}, 32'd0);
        next_cycle();
        dbus_ack = 1'b0;
        @(negedge clk);
        check("rb_late_ack_req", {31'd0, dbus_req}, 32'd0);
        check("rb_late_ack_stall", {31'd0, m_stall}, 32'd0);
        check("rb_rd_data", m_rd_data, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
